// File: rtl/dii_package.sv
// ---------------------------------------------------------------------------
// dii_package: DII flit type and shared addresses for the debug ring.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam logic [15:0] DII_BROADCAST_ID = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/ring_router_demux.sv
// ---------------------------------------------------------------------------
// ring_router_demux: steers each ring worm to the local module or the next hop.
// Optional broadcast delivery: RING_ROUTER_DEMUX_BROADCAST_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ring_router_demux
  import dii_package::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  dii_flit     in_ring,
  output logic        in_ring_ready,
  output dii_flit     out_local,
  input  logic        out_local_ready,
  output dii_flit     out_ring,
  input  logic        out_ring_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOCAL = 2'd1;
  localparam logic [1:0] S_RING  = 2'd2;
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
  localparam logic [1:0] S_BCAST = 2'd3;
`endif

  logic [1:0] state_q, state_d;
  logic       to_local, to_ring, sel_ready, xfer;
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
  logic       to_bcast;
  logic       taken_local_q, taken_local_d;
  logic       taken_ring_q, taken_ring_d;
`endif

  assign xfer = in_ring.valid & in_ring_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // The header decision is made combinationally so it applies in the header's own cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_ring.valid & ~in_ring.last) begin
          if (to_local)     state_d = S_LOCAL;
          else if (to_ring) state_d = S_RING;
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
          else              state_d = S_BCAST;
`endif
        end
      end
      default: begin
        if (xfer & in_ring.last) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    to_local = 1'b0;
    to_ring  = 1'b0;
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
    to_bcast = 1'b0;
`endif
    case (state_q)
      S_LOCAL: to_local = 1'b1;
      S_RING:  to_ring  = 1'b1;
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
      S_BCAST: to_bcast = 1'b1;
`endif
      default: begin
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
        if (in_ring.data == DII_BROADCAST_ID) to_bcast = 1'b1;
        else
`endif
        if (in_ring.data == id) to_local = 1'b1;
        else                    to_ring  = 1'b1;
      end
    endcase

    out_local = in_ring;
    out_ring  = in_ring;
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
    out_local.valid = in_ring.valid & (to_local | (to_bcast & ~taken_local_q));
    out_ring.valid  = in_ring.valid & (to_ring  | (to_bcast & ~taken_ring_q));
    sel_ready = to_bcast ? ((taken_local_q | out_local_ready) & (taken_ring_q | out_ring_ready))
                         : ((to_local & out_local_ready) | (to_ring & out_ring_ready));
`else
    out_local.valid = in_ring.valid & to_local;
    out_ring.valid  = in_ring.valid & to_ring;
    sel_ready = (to_local & out_local_ready) | (to_ring & out_ring_ready);
`endif
    in_ring_ready = (state_q == S_IDLE) ? (in_ring.valid & sel_ready) : sel_ready;
  end

`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
  // A broadcast flit is held until both sides took it; the flags stop re-delivery.
  always_comb begin
    taken_local_d = taken_local_q;
    taken_ring_d  = taken_ring_q;
    if (xfer) begin
      taken_local_d = 1'b0;
      taken_ring_d  = 1'b0;
    end else if (to_bcast & in_ring.valid) begin
      taken_local_d = taken_local_q | (out_local.valid & out_local_ready);
      taken_ring_d  = taken_ring_q  | (out_ring.valid & out_ring_ready);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_local_q <= 1'b0;
      taken_ring_q  <= 1'b0;
    end else begin
      taken_local_q <= taken_local_d;
      taken_ring_q  <= taken_ring_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ring_router_demux.sv
// ---------------------------------------------------------------------------
// tb_ring_router_demux: vector table, corner sequences and randomized worms vs. model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ring_router_demux;
  import dii_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  dii_flit     in_ring, out_local, out_ring;
  logic        in_ring_ready, lr, rr;

  int total = 0;
  int bad   = 0;

  ring_router_demux dut (
    .clk(clk), .rst(rst), .id(id),
    .in_ring(in_ring), .in_ring_ready(in_ring_ready),
    .out_local(out_local), .out_local_ready(lr),
    .out_ring(out_ring), .out_ring_ready(rr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] id;
    logic v, l;
    logic [15:0] d;
    logic lr, rr;
    logic elv, erv, erdy;
  } vec_t;

  vec_t vt[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(logic [15:0] i, logic v, logic l, logic [15:0] d, logic a, logic b);
    id = i; in_ring.valid = v; in_ring.last = l; in_ring.data = d; lr = a; rr = b;
  endtask

  task automatic cyc(string tag, logic elv, logic erv, logic erdy);
    @(negedge clk);
    chk({tag, ".local_valid"}, 32'(out_local.valid), 32'(elv));
    chk({tag, ".ring_valid"}, 32'(out_ring.valid), 32'(erv));
    chk({tag, ".in_ready"}, 32'(in_ring_ready), 32'(erdy));
    if (elv) chk({tag, ".local_flit"}, 32'({out_local.last, out_local.data}), 32'({in_ring.last, in_ring.data}));
    if (erv) chk({tag, ".ring_flit"}, 32'({out_ring.last, out_ring.data}), 32'({in_ring.last, in_ring.data}));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drv(16'h0005, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference: destination decided from the header alone, remembered for the worm.
  int          m_dest;
  bit          m_dl, m_dr;
  logic [16:0] exp_l[$], exp_r[$], got_l[$], got_r[$];

  function automatic int classify(logic [15:0] d, logic [15:0] i);
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
    if (d == 16'hFFFF) return 2;
`endif
    if (d == i) return 0;
    return 1;
  endfunction

  initial begin
    logic [15:0] bc;
    bc = 16'hFFFF;
    rst = 1'b0;
    do_reset();

    //       id       v  l  data      lr rr  elv erv rdy
    vt.push_back('{16'h5, 0, 0, 16'h0000, 1, 1, 0, 0, 0});
    vt.push_back('{16'h5, 1, 1, 16'h0005, 1, 1, 1, 0, 1});
    vt.push_back('{16'h5, 1, 1, 16'h0005, 0, 1, 1, 0, 0});
    vt.push_back('{16'h5, 1, 0, 16'h0009, 1, 1, 0, 1, 1});
    vt.push_back('{16'h5, 1, 0, 16'h00A1, 1, 0, 0, 1, 0});
    vt.push_back('{16'h5, 1, 0, 16'h00A1, 1, 0, 0, 1, 0});
    vt.push_back('{16'h5, 1, 0, 16'h00A1, 1, 1, 0, 1, 1});
    vt.push_back('{16'h5, 1, 1, 16'h00A2, 1, 1, 0, 1, 1});
    vt.push_back('{16'h5, 1, 0, 16'h0005, 1, 1, 1, 0, 1});
    vt.push_back('{16'h5, 1, 1, 16'h00B1, 1, 0, 1, 0, 1});
    vt.push_back('{16'h5, 1, 1, 16'h0007, 0, 1, 0, 1, 1});
    vt.push_back('{16'h5, 0, 0, 16'h0005, 1, 1, 0, 0, 0});
    vt.push_back('{16'h5, 1, 0, 16'h0005, 1, 1, 1, 0, 1});
    vt.push_back('{16'h9, 1, 0, 16'h0009, 1, 1, 1, 0, 1});
    vt.push_back('{16'h9, 1, 1, 16'h0009, 1, 1, 1, 0, 1});
    vt.push_back('{16'h9, 1, 1, 16'h0009, 1, 1, 1, 0, 1});
    vt.push_back('{16'h5, 1, 0, 16'h0009, 1, 0, 0, 1, 0});
    vt.push_back('{16'h9, 1, 0, 16'h0009, 1, 1, 0, 1, 1});
    vt.push_back('{16'h5, 1, 1, 16'h000C, 1, 1, 0, 1, 1});
    vt.push_back('{16'h5, 0, 0, 16'h0000, 0, 0, 0, 0, 0});
    vt.push_back('{16'h5, 1, 0, 16'h0005, 1, 1, 1, 0, 1});
    vt.push_back('{16'h5, 0, 0, 16'h0000, 1, 0, 0, 0, 1});
    vt.push_back('{16'h5, 1, 1, 16'h000E, 1, 0, 1, 0, 1});
`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
    vt.push_back('{16'h5, 1, 1, bc, 1, 1, 1, 1, 1});
    vt.push_back('{bc,    1, 1, bc, 1, 1, 1, 1, 1});
`else
    vt.push_back('{16'h5, 1, 1, bc, 1, 1, 0, 1, 1});
    vt.push_back('{bc,    1, 1, bc, 1, 1, 1, 0, 1});
`endif

    for (int i = 0; i < vt.size(); i++) begin
      drv(vt[i].id, vt[i].v, vt[i].l, vt[i].d, vt[i].lr, vt[i].rr);
      cyc($sformatf("vec%0d", i), vt[i].elv, vt[i].erv, vt[i].erdy);
    end

    // Reset in the middle of a local worm: next flit must be a fresh header.
    drv(16'h5, 1, 0, 16'h0005, 1, 1); cyc("rst_hdr", 1, 0, 1);
    drv(16'h5, 1, 0, 16'h00D1, 1, 1); cyc("rst_f1", 1, 0, 1);
    drv(16'h5, 0, 0, 16'h0000, 1, 1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    drv(16'h5, 1, 1, 16'h0009, 1, 1); cyc("rst_after", 0, 1, 1);

`ifdef RING_ROUTER_DEMUX_BROADCAST_EN
    drv(16'h5, 1, 0, bc, 1, 0);       cyc("bc_h0", 1, 1, 0);
    cyc("bc_h1", 0, 1, 0);
    cyc("bc_h2", 0, 1, 0);
    drv(16'h5, 1, 0, bc, 1, 1);       cyc("bc_h3", 0, 1, 1);
    drv(16'h5, 1, 1, 16'h00F2, 1, 1); cyc("bc_f2", 1, 1, 1);
    drv(16'h5, 1, 1, 16'h0005, 1, 1); cyc("bc_next", 1, 0, 1);
`else
    drv(16'h5, 1, 0, bc, 1, 1);       cyc("ff_h", 0, 1, 1);
    drv(16'h5, 1, 1, 16'h00F2, 1, 1); cyc("ff_f2", 0, 1, 1);
`endif

    // Randomized worms against the reference model and per-output scoreboard.
    do_reset();
    m_dest = -1; m_dl = 0; m_dr = 0;
    begin
      bit hold = 0;
      for (int c = 0; c < 3000; c++) begin
        int   dest;
        bit   hdr, elv, erv, erdy, raw;
        if ($urandom_range(9) == 0) id = ($urandom_range(1) != 0) ? 16'h0009 : 16'h0005;
        if (!hold) begin
          in_ring.valid = ($urandom_range(3) != 0);
          in_ring.last  = ($urandom_range(2) == 0);
          case ($urandom_range(3))
            0: in_ring.data = 16'h0005;
            1: in_ring.data = 16'h0009;
            2: in_ring.data = 16'hFFFF;
            default: in_ring.data = 16'($urandom);
          endcase
        end
        lr = ($urandom_range(3) != 0);
        rr = ($urandom_range(3) != 0);

        hdr  = (m_dest < 0);
        dest = hdr ? classify(in_ring.data, id) : m_dest;
        elv  = in_ring.valid && (dest == 0 || (dest == 2 && !m_dl));
        erv  = in_ring.valid && (dest == 1 || (dest == 2 && !m_dr));
        raw  = (dest == 0) ? lr : (dest == 1) ? rr : ((m_dl | lr) & (m_dr | rr));
        erdy = hdr ? (in_ring.valid & raw) : raw;

        @(negedge clk);
        chk("rnd.local_valid", 32'(out_local.valid), 32'(elv));
        chk("rnd.ring_valid", 32'(out_ring.valid), 32'(erv));
        chk("rnd.in_ready", 32'(in_ring_ready), 32'(erdy));
        if (out_local.valid && lr) got_l.push_back({out_local.last, out_local.data});
        if (out_ring.valid && rr)  got_r.push_back({out_ring.last, out_ring.data});
        @(posedge clk); #1;

        if (in_ring.valid) begin
          if (erdy) begin
            if (dest != 1) exp_l.push_back({in_ring.last, in_ring.data});
            if (dest != 0) exp_r.push_back({in_ring.last, in_ring.data});
            m_dl = 0; m_dr = 0;
            m_dest = in_ring.last ? -1 : dest;
            hold = 0;
          end else begin
            if (dest == 2) begin m_dl |= lr; m_dr |= rr; end
            if (hdr && !in_ring.last) m_dest = dest;
            hold = 1;
          end
        end else begin
          hold = 0;
        end
      end
    end

    chk("sb.local_count", 32'(got_l.size()), 32'(exp_l.size()));
    chk("sb.ring_count", 32'(got_r.size()), 32'(exp_r.size()));
    for (int i = 0; i < exp_l.size() && i < got_l.size(); i++)
      chk($sformatf("sb.local[%0d]", i), 32'(got_l[i]), 32'(exp_l[i]));
    for (int i = 0; i < exp_r.size() && i < got_r.size(); i++)
      chk($sformatf("sb.ring[%0d]", i), 32'(got_r[i]), 32'(exp_r[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ring_router_demux.md
# ring_router_demux

Ingress splitter of a debug ring router. It takes the DII flit stream arriving on the ring and steers each worm to one of two places: the local debug module when the worm's destination equals this router's `id`, or onward to the next ring hop otherwise. The routing decision is made on the header flit and held for the whole worm. It sits upstream of the local/ring merge stage in the same router.

## Interface
- No parameters. Module ID and broadcast address are 16 bit, matching `dii_flit.data`.
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `id` input 16: this router's module address. Sampled only on header flits.
- `in_ring` input `dii_flit` (valid, last, data[15:0]): flits from the previous ring hop.
- `in_ring_ready` output 1: `in_ring` flit is consumed this cycle.
- `out_local` output `dii_flit`: flits addressed to the local module.
- `out_local_ready` input 1: local module accepts the flit.
- `out_ring` output `dii_flit`: flits forwarded to the next hop.
- `out_ring_ready` input 1: next hop accepts the flit.

## Operation
- **Header flit.** The first flit after reset, and every flit after a consumed `last`, is a header. Its `data` is the destination address.
- **States:** IDLE, WORM_LOCAL, WORM_RING, plus WORM_BCAST when configured in.
- **IDLE with `in_ring.valid`:**
  - `data == id` routes to local.
  - Otherwise the flit routes to ring.
  - The flit is presented on the chosen output with `valid=1`.
  - `in_ring_ready` equals that output's ready.
  - Move to WORM_x only if `last==0`; the move happens whether or not the header was consumed this cycle.
  - A single-flit worm (`last==1`) stays in IDLE.
- **WORM_x:**
  - Pass `in_ring` through to the selected output, with `valid` following `in_ring.valid`.
  - `in_ring_ready` equals the selected output's ready.
  - Return to IDLE when `valid & last & ready`.
- **Unselected output:** always `valid=0`; its data and last are don't-care. The bench checks data and last only when valid is high.
- **`id` changes mid-worm:** no effect on the current worm.
- **No flit transfer latency:** all outputs are combinational from `in_ring` and state.
- **Reset:**
  - state = IDLE, broadcast flags cleared.
  - `out_local.valid = out_ring.valid = 0` until `in_ring.valid`.
  - `in_ring_ready = 0` while `in_ring.valid = 0` in IDLE.
  - Reset mid-worm discards the worm context: the next valid flit is treated as a header.

## Timing
- Zero-cycle path from `in_ring` to `out_*` and from `out_*_ready` to `in_ring_ready`.
- State updates on `posedge clk`. The header decision is visible in the same cycle as the header.
- A flit is consumed exactly when `in_ring.valid & in_ring_ready`. One flit per cycle maximum.
- Back-to-back worms: a `last` consumed in cycle N lets the header in cycle N+1 be routed with no bubble.
- Backpressure on the unselected output never stalls the worm.

## Configuration
- **`RING_ROUTER_DEMUX_BROADCAST_EN` defined:**
  - A header with `data == 16'hFFFF` is delivered to both outputs; a non-`last` header enters WORM_BCAST.
  - Two registered flags, `taken_local` and `taken_ring`, track delivery per flit.
  - `out_x.valid = in_ring.valid & !taken_x`.
  - `in_ring_ready = (taken_local | out_local_ready) & (taken_ring | out_ring_ready)`.
  - If only one output handshakes, set its flag and hold the flit.
  - Clear both flags when the flit is consumed.
  - No flit is ever duplicated on one output or lost on the other.
  - Leave WORM_BCAST on a consumed `last`.
  - A single-flit broadcast header handled in IDLE uses the same flag mechanism.
- **Macro undefined:** 16'hFFFF is an ordinary address (it routes to ring unless `id == 16'hFFFF`). No WORM_BCAST state and no flags.

## Structure
- `dii_flit` already lives in `dii_package`. Add `DII_BROADCAST_ID = 16'hFFFF` there.
- Keep the state enum local to the module.
- Single module, no sub-module. The broadcast flag logic stays inline under the macro guard.

## Test plan
- **Single-flit local hit:** `id=16'h0005`, header data=5, last=1, `out_local_ready=1` -> `out_local.valid=1` same cycle, `in_ring_ready=1`, `out_ring.valid=0`, state stays IDLE.
- **3-flit worm to 16'h0009, `id=5`:** ring ready low for 2 cycles on flit 2 -> flits appear in order on `out_ring` only, `in_ring_ready=0` during the stall, IDLE after the third flit.
- **Back-to-back worms:** local worm (2 flits) immediately followed by a ring worm (1 flit) -> no bubble, the second header is routed to ring in the cycle after the first `last`.
- **Reset mid-worm:** after flit 1 of a 4-flit local worm, assert `rst` for 1 cycle, then present data=9, last=1 -> treated as a header and routed to ring.
- **Broadcast (macro on):** 2-flit worm to 16'hFFFF, `out_local_ready=1`, `out_ring_ready=0` for 3 cycles -> local receives flit 1 exactly once, `in_ring_ready` stays 0 until ring accepts, then both outputs see flit 2 once.
- **Macro off:** the same 16'hFFFF worm with `id=5` -> routed to ring only.
